ldm_stm_sequencer: RTL and testbench

Multi-cycle sequencer for ARM block data transfers (LDM/STM, all four IA/IB/DA/DB modes, optional base writeback). It sits directly upstream of the register file. It drives the register file's second read port address for stores and its write port for loads and base writeback. It also drives a request/ready data-memory interface and stalls the core via busy while active.

---
 rtl/ldm_stm_sequencer_pkg.sv | 23 ++
 rtl/ldm_stm_sequencer_reglist_scan.sv | 22 ++
 rtl/ldm_stm_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef logic [15:0] reglist_t;

  // Writeback is dropped when an LDM reloads the base itself, and never targets R15.
  function automatic logic wb_taken(input logic     load,
                                    input logic     wback,
                                    input logic [3:0] rn,
                                    input reglist_t list);
    return wback && !(load && list[rn]) && (rn != 4'd15);
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_reglist_scan.sv
// Combinational scan of a register mask: lowest set index, any-set flag and popcount.
module reglist_scan
  import ldm_stm_pkg::*;
(
  input  reglist_t   mask_i,
  output logic [3:0] idx_o,
  output logic       valid_o,
  output logic [4:0] count_o
);

  // Walk from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx_o   = 4'd0;
    count_o = 5'd0;
    valid_o = |mask_i;
    for (int i = 15; i >= 0; i--) begin
      idx_o   = mask_i[i] ? 4'(i) : idx_o;
      count_o = count_o + 5'(mask_i[i]);
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ARM LDM/STM sequencer: walks the register list over a request/ready memory port,
// feeds the register file read/write ports and stalls the core while active.
module ldm_stm_sequencer
  import ldm_stm_pkg::state_e, ldm_stm_pkg::IDLE, ldm_stm_pkg::XFER, ldm_stm_pkg::WB,
         ldm_stm_pkg::DONE, ldm_stm_pkg::reglist_t, ldm_stm_pkg::wb_taken;
#(
  parameter int DW         = 32,
  parameter int WORD_BYTES = ldm_stm_pkg::WORD_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          load,
  input  logic          pre,
  input  logic          up,
  input  logic          wback,
  input  logic [3:0]    rn,
  input  logic [DW-1:0] base,
  input  logic [15:0]   reg_list,
  output logic [3:0]    ra,
  input  logic [DW-1:0] rd,
  output logic [3:0]    wa,
  output logic          we,
  output logic [DW-1:0] wd,
  output logic          pc_we,
  output logic [DW-1:0] pc_wd,
  output logic          mem_req,
  output logic          mem_write,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  reglist_t      mask_q, mask_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] fbase_q, fbase_d;
  logic          load_q, load_d;
  logic          wb_q, wb_d;
  logic [3:0]    rn_q, rn_d;

  reglist_t      scan_mask_s;
  reglist_t      rem_mask_s;
  logic [3:0]    idx_s;
  logic          any_s;
  logic [4:0]    cnt_s;
  logic [DW-1:0] step_s;
  logic [DW-1:0] span_s;
  logic [DW-1:0] start_addr_s;

  // One scanner: popcount of the incoming list in IDLE, next register during XFER.
  assign scan_mask_s = (state_q == IDLE) ? reg_list : mask_q;

  reglist_scan u_scan (
    .mask_i  (scan_mask_s),
    .idx_o   (idx_s),
    .valid_o (any_s),
    .count_o (cnt_s)
  );

  assign step_s     = DW'(WORD_BYTES);
  assign span_s     = DW'(cnt_s) * step_s;
  assign rem_mask_s = mask_q & ~(16'd1 << idx_s);

  // Lowest address of the transferred block; registers always go out ascending.
  always_comb begin
    case ({pre, up})
      2'b01:   start_addr_s = base;
      2'b11:   start_addr_s = base + step_s;
      2'b00:   start_addr_s = base - span_s + step_s;
      2'b10:   start_addr_s = base - span_s;
      default: start_addr_s = base;
    endcase
  end

  // State and transfer-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 16'd0;
      addr_q  <= {DW{1'b0}};
      fbase_q <= {DW{1'b0}};
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      rn_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      fbase_q <= fbase_d;
      load_q  <= load_d;
      wb_q    <= wb_d;
      rn_q    <= rn_d;
    end
  end

  // Next-state and output decode; load data is forwarded to the register file in the ready cycle.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    fbase_d   = fbase_q;
    load_d    = load_q;
    wb_d      = wb_q;
    rn_d      = rn_q;
    ra        = 4'd0;
    wa        = 4'd0;
    we        = 1'b0;
    wd        = {DW{1'b0}};
    pc_we     = 1'b0;
    pc_wd     = {DW{1'b0}};
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {DW{1'b0}};
    mem_wdata = {DW{1'b0}};
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load_d  = load;
          rn_d    = rn;
          mask_d  = reg_list;
          addr_d  = start_addr_s;
          fbase_d = up ? (base + span_s) : (base - span_s);
          wb_d    = wb_taken(load, wback, rn, reg_list);
          state_d = any_s ? XFER : DONE;
        end else begin
          state_d = IDLE;
        end
      end

      XFER: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_write = ~load_q;
        mem_addr  = addr_q;
        ra        = idx_s;
        mem_wdata = rd;
        if (mem_ready) begin
          if (load_q) begin
            if (idx_s == 4'd15) begin
              pc_we = 1'b1;
              pc_wd = mem_rdata;
            end else begin
              we = 1'b1;
              wa = idx_s;
              wd = mem_rdata;
            end
          end else begin
            we = 1'b0;
          end
          mask_d = rem_mask_s;
          addr_d = addr_q + step_s;
          if (rem_mask_s == 16'd0) begin
            state_d = wb_q ? WB : DONE;
          end else begin
            state_d = XFER;
          end
        end else begin
          state_d = XFER;
        end
      end

      WB: begin
        busy    = 1'b1;
        we      = 1'b1;
        wa      = rn_q;
        wd      = fbase_q;
        state_d = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench: each launched transfer pushes its expected memory, register-file,
// PC and completion events; a negedge monitor pops and compares as the DUT presents them.
module tb_ldm_stm_sequencer;

  localparam int DW = 32;

  typedef enum int {EV_MEM, EV_RF, EV_PC, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  idx;
    logic        wr;
    int          cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, load, pre, up, wback;
  logic [3:0]    rn;
  logic [DW-1:0] base;
  logic [15:0]   reg_list;
  logic [3:0]    ra;
  logic [DW-1:0] rd;
  logic [3:0]    wa;
  logic          we;
  logic [DW-1:0] wd;
  logic          pc_we;
  logic [DW-1:0] pc_wd;
  logic          mem_req, mem_write;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_ready = 1'b0;
  logic          busy, done;

  ev_t         expq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          stall_until = 0;
  logic        rdy_always = 1'b1;
  logic        seed_regs = 1'b1;
  logic [31:0] regs [16];
  logic [31:0] mem_seed = 32'h1357_9BDF;

  always #5 clk = ~clk;

  ldm_stm_sequencer #(.DW(DW), .WORD_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load(load), .pre(pre), .up(up),
    .wback(wback), .rn(rn), .base(base), .reg_list(reg_list), .ra(ra), .rd(rd),
    .wa(wa), .we(we), .wd(wd), .pc_we(pc_we), .pc_wd(pc_wd), .mem_req(mem_req),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  // Environment: register file and memory the sequencer talks to.
  assign rd        = regs[ra];
  assign mem_rdata = (mem_req && !mem_write) ? mem_word(mem_addr) : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (seed_regs) begin
      for (int i = 0; i < 16; i++) regs[i] <= $urandom;
    end else begin
      if (we)    regs[wa] <= wd;
      if (pc_we) regs[15] <= pc_wd;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc < stall_until) mem_ready = 1'b0;
      else mem_ready = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%08h required=no_event (pending=%0d)", name, act, expq.size());
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (expq.size() == 0 || expq[0].kind != EV_MEM) unexpected("unexpected_mem_req", mem_addr);
        else begin
          check("mem_addr", mem_addr, expq[0].addr);
          check("mem_write", 32'(mem_write), 32'(expq[0].wr));
          check("ra", 32'(ra), 32'(expq[0].idx));
          if (expq[0].wr) check("mem_wdata", mem_wdata, expq[0].data);
          check("busy_xfer", 32'(busy), 32'd1);
          if (mem_ready) void'(expq.pop_front());
        end
      end
      if (we) begin
        if (expq.size() == 0 || expq[0].kind != EV_RF) unexpected("unexpected_we", {24'd0, wa, 4'd0});
        else begin
          check("wa", 32'(wa), 32'(expq[0].idx));
          check("wd", wd, expq[0].data);
          void'(expq.pop_front());
        end
      end
      if (pc_we) begin
        if (expq.size() == 0 || expq[0].kind != EV_PC) unexpected("unexpected_pc_we", pc_wd);
        else begin
          check("pc_wd", pc_wd, expq[0].data);
          void'(expq.pop_front());
        end
      end
      if (done) begin
        if (expq.size() == 0 || expq[0].kind != EV_DONE) unexpected("unexpected_done", 32'(cyc));
        else begin
          check("busy_at_done", 32'(busy), 32'd0);
          if (expq[0].cyc >= 0) check("done_cycle", 32'(cyc), 32'(expq[0].cyc));
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_pc_we"}, 32'(pc_we), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_ra"}, 32'(ra), 32'd0);
    check({tag, "_wa"}, 32'(wa), 32'd0);
    check({tag, "_wd"}, wd, 32'd0);
    check({tag, "_pc_wd"}, pc_wd, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0_pending", expq.size());
      expq.delete();
    end
  endtask

  // Reference model: the listed registers occupy a contiguous word block below or above
  // the base and are moved lowest index to lowest address.
  task automatic run_xfer(input logic ld, input logic pr, input logic u, input logic w,
                          input logic [3:0] r, input logic [31:0] b, input logic [15:0] lst,
                          input int stall, input bit abort);
    int          n, k, s;
    logic [31:0] lo, a, fin;
    bit          wbt;
    drain();
    @(negedge clk);
    n = $countones(lst);
    s = cyc + 1;
    if (u) lo = b + (pr ? 32'd4 : 32'd0);
    else   lo = b - (pr ? 32'd4 : 32'd0) - 32'(4 * (n - 1));
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        a = lo + 32'(4 * k);
        k++;
        expq.push_back('{kind: EV_MEM, addr: a, data: (ld ? mem_word(a) : regs[i]),
                         idx: 4'(i), wr: !ld, cyc: -1});
        if (ld && i == 15)
          expq.push_back('{kind: EV_PC, addr: a, data: mem_word(a), idx: 4'(i), wr: 1'b0, cyc: -1});
        else if (ld)
          expq.push_back('{kind: EV_RF, addr: a, data: mem_word(a), idx: 4'(i), wr: 1'b0, cyc: -1});
      end
    end
    wbt = w && (n != 0) && !(ld && lst[r]);
    fin = u ? (b + 32'(4 * n)) : (b - 32'(4 * n));
    if (wbt)
      expq.push_back('{kind: EV_RF, addr: 32'd0, data: fin, idx: r, wr: 1'b0, cyc: -1});
    expq.push_back('{kind: EV_DONE, addr: 32'd0, data: 32'd0, idx: 4'd0, wr: 1'b0,
                     cyc: (rdy_always ? s + n + (wbt ? 1 : 0) + stall : -1)});
    stall_until = s + stall;
    start = 1'b1; load = ld; pre = pr; up = u; wback = w; rn = r; base = b; reg_list = lst;
    @(posedge clk);
    #1;
    // Second cycle: start held high with scrambled fields must be ignored.
    load = 1'($urandom); pre = 1'($urandom); up = 1'($urandom); wback = 1'($urandom);
    rn = 4'($urandom); base = $urandom; reg_list = 16'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (abort) begin
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      expq.delete();
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          m;
    logic [3:0]  r;
    logic [31:0] b;
    logic [15:0] lst;
    start = 1'b0; load = 1'b0; pre = 1'b0; up = 1'b0; wback = 1'b0;
    rn = 4'd0; base = 32'd0; reg_list = 16'd0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    seed_regs = 1'b0;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    rdy_always = 1'b1;
    run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  32'h100, 16'h000A, 0, 1'b0); // LDMIA r0!,{r1,r3}
    run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h4070, 0, 1'b0); // STMDB r13!,{r4-r6,r14}
    run_xfer(1'b1, 1'b0, 1'b1, 1'b0, 4'd2,  32'h040, 16'h8001, 0, 1'b0); // LDMIA r2,{r0,r15}
    run_xfer(1'b0, 1'b1, 1'b1, 1'b0, 4'd1,  32'h100, 16'h0004, 3, 1'b0); // STMIB r1,{r2} stalled
    run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd1,  32'h300, 16'h0006, 0, 1'b0); // LDMIA r1!,{r1,r2}
    run_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  32'h500, 16'h0000, 0, 1'b0); // empty list
    run_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  32'h600, 16'h002A, 0, 1'b0); // STMIA r3!,{r1,r3,r5}
    run_xfer(1'b1, 1'b0, 1'b0, 1'b1, 4'd7,  32'h800, 16'h00F0, 0, 1'b0); // LDMDA r7!,{r4-r7}
    run_xfer(1'b1, 1'b0, 1'b1, 1'b0, 4'd4,  32'h700, 16'h000F, 0, 1'b1); // aborted LDM
    run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 4'd9,  32'h900, 16'h0C03, 0, 1'b0); // LDMIB after abort

    drain();
    rdy_always = 1'b0;
    for (int it = 0; it < 80; it++) begin
      m   = $urandom_range(0, 7);
      lst = (m == 0) ? 16'h0000 : (m == 1) ? 16'hFFFF : 16'($urandom & $urandom);
      r   = 4'($urandom_range(0, 14));
      b   = (m < 4) ? regs[r] : ($urandom & 32'hFFFF_FFFC);
      run_xfer(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), r, b, lst,
               $urandom_range(0, 2), 1'b0);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
